// File: rtl/serial_row_loader_if.sv
// serial_row_loader_if: control, serial input, word write and row output bundle.
// master drives the load controls and bitstream, slave is the loader.
interface serial_row_loader_if #(
  parameter int WORD_W       = 16,
  parameter int MAX_FEATURES = 15,
  parameter int ADDR_WIDTH   = 12,
  parameter int ROW_W        = WORD_W*(MAX_FEATURES+1),
  parameter int COL_W        = 4
);
  logic                  start;
  logic [COL_W-1:0]      feat;
  logic [ADDR_WIDTH-1:0] data_points;
  logic                  S;
  logic                  S_EN;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_row;
  logic [COL_W-1:0]      wr_col;
  logic [WORD_W-1:0]     wr_data;
  logic                  row_valid;
  logic [ROW_W-1:0]      row_data;
  logic                  busy;
  logic                  done_;
  logic                  err;

  modport master (
    output start, feat, data_points, S, S_EN,
    input  wr_en, wr_row, wr_col, wr_data,
    input  row_valid, row_data, busy, done_, err
  );

  modport slave (
    input  start, feat, data_points, S, S_EN,
    output wr_en, wr_row, wr_col, wr_data,
    output row_valid, row_data, busy, done_, err
  );
endinterface

// File: rtl/serial_row_loader.sv
// serial_row_loader: LSB-first bitstream to WORD_W words, rows of feat+1 words.
// Define SERIAL_PARITY_EN for a trailing even-parity bit per word driving err.
module serial_row_loader #(
  parameter int WORD_W       = 16,
  parameter int MAX_FEATURES = 15,
  parameter int ADDR_WIDTH   = 12,
  parameter int ROW_W        = WORD_W*(MAX_FEATURES+1),
  parameter int COL_W        = 4
) (
  input logic CLK,
  input logic RST,
  serial_row_loader_if.slave bus
);

`ifdef SERIAL_PARITY_EN
  localparam int NBITS = WORD_W + 1;
`else
  localparam int NBITS = WORD_W;
`endif
  localparam int BCW = $clog2(NBITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(NBITS - 1);
  localparam logic [COL_W-1:0] FMAX = COL_W'(MAX_FEATURES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [COL_W-1:0]      feat_q;
  logic [COL_W-1:0]      col;
  logic [ADDR_WIDTH-1:0] dp_q;
  logic [ADDR_WIDTH-1:0] row;
  logic [BCW-1:0]        bitcnt;
  logic [WORD_W-1:0]     shreg;
  logic [ROW_W-1:0]      rowbuf;
  logic [ROW_W-1:0]      merged;
  logic                  word_full;
  logic                  last_word;

  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_row_q;
  logic [COL_W-1:0]      wr_col_q;
  logic [WORD_W-1:0]     wr_data_q;
  logic                  row_valid_q;
  logic [ROW_W-1:0]      row_data_q;
  logic                  busy_c;
  logic                  done_c;

  logic                  accept;
  logic                  take;
  logic [COL_W-1:0]      feat_cl;
  logic                  is_last;

  assign accept  = bus.start && (state != LOAD);
  // no bits are consumed once the final word of the dataset is assembled
  assign take    = (state == LOAD) && bus.S_EN && !last_word;
  assign feat_cl = (bus.feat > FMAX) ? FMAX : bus.feat;
  assign is_last = (row == dp_q) && (col == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = LOAD;
      LOAD:    if (wr_en_q && last_word) state_nx = DONE;
      DONE:    if (bus.start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    unique case (state)
      LOAD:    busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    merged = rowbuf;
    merged[int'(col)*WORD_W +: WORD_W] = shreg;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      feat_q      <= '0;
      col         <= '0;
      dp_q        <= '0;
      row         <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      rowbuf      <= '0;
      word_full   <= 1'b0;
      last_word   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      wr_data_q   <= '0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
    end else begin
      wr_en_q     <= 1'b0;
      row_valid_q <= 1'b0;
      word_full   <= 1'b0;
      if (accept) begin
        feat_q    <= feat_cl;
        dp_q      <= bus.data_points;
        col       <= feat_cl;
        row       <= '0;
        bitcnt    <= '0;
        rowbuf    <= '0;
        last_word <= 1'b0;
      end else begin
        if (take) begin
          for (int i = 0; i < WORD_W; i++) begin
            if (bitcnt == BCW'(i)) shreg[i] <= bus.S;
          end
          if (bitcnt == LAST_BIT) begin
            bitcnt    <= '0;
            word_full <= 1'b1;
            if (is_last) last_word <= 1'b1;
          end else begin
            bitcnt <= bitcnt + 1'b1;
          end
        end
        // shreg may already take bit 0 of the next word on this edge
        if (word_full) begin
          wr_en_q   <= 1'b1;
          wr_row_q  <= row;
          wr_col_q  <= col;
          wr_data_q <= shreg;
          if (col == '0) begin
            row_valid_q <= 1'b1;
            row_data_q  <= merged;
            rowbuf      <= '0;
            col         <= feat_q;
            if (!last_word) row <= row + 1'b1;
          end else begin
            rowbuf <= merged;
            col    <= col - 1'b1;
          end
        end
      end
    end
  end

`ifdef SERIAL_PARITY_EN
  logic err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (take && (bitcnt == LAST_BIT) && (bus.S != ^shreg)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_row    = wr_row_q;
  assign bus.wr_col    = wr_col_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.row_valid = row_valid_q;
  assign bus.row_data  = row_data_q;
  assign bus.busy      = busy_c;
  assign bus.done_     = done_c;

endmodule

// File: tb/tb_serial_row_loader.sv
// tb_serial_row_loader: directed vector table plus hand-written load sequences.
// Expected words, rows and latencies are hand-computed constants.
module tb_serial_row_loader;
  localparam int WORD_W = 16;
  localparam int MAXF   = 15;
  localparam int AW     = 12;
  localparam int ROW_W  = 256;
  localparam int COL_W  = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  serial_row_loader_if #(
    .WORD_W(WORD_W), .MAX_FEATURES(MAXF), .ADDR_WIDTH(AW),
    .ROW_W(ROW_W), .COL_W(COL_W)
  ) bus ();

  serial_row_loader #(
    .WORD_W(WORD_W), .MAX_FEATURES(MAXF), .ADDR_WIDTH(AW),
    .ROW_W(ROW_W), .COL_W(COL_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0]  wr_q[$];
  logic [255:0] row_q[$];

  always @(negedge CLK) begin
    if (bus.wr_en) wr_q.push_back({bus.wr_row, bus.wr_col, bus.wr_data});
    if (bus.row_valid) row_q.push_back(bus.row_data);
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.S    = b;
    bus.S_EN = 1'b1;
    tick();
  endtask

  task automatic send_word(input logic [15:0] w, input bit gap);
    for (int i = 0; i < WORD_W; i++) begin
      if (gap) begin
        bus.S_EN = 1'b0;
        bus.S    = ~w[i];
        tick();
      end
      send_bit(w[i]);
    end
`ifdef SERIAL_PARITY_EN
    if (gap) begin
      bus.S_EN = 1'b0;
      tick();
    end
    send_bit(^w);
`endif
  endtask

  task automatic do_start(input logic [3:0] f, input logic [11:0] d);
    bus.start       = 1'b1;
    bus.feat        = f;
    bus.data_points = d;
    tick();
    bus.start = 1'b0;
  endtask

  typedef struct {
    logic [15:0] word;
    bit          gap;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base;
    int rbase;
    logic [15:0] w;
    logic [31:0] e;
    logic [255:0] rd;

    vecs[0] = '{16'hA5C3, 1'b0, 16'hA5C3};
    vecs[1] = '{16'hA5C3, 1'b1, 16'hA5C3};
    vecs[2] = '{16'h0000, 1'b0, 16'h0000};
    vecs[3] = '{16'hFFFF, 1'b1, 16'hFFFF};
    vecs[4] = '{16'h8001, 1'b0, 16'h8001};
    vecs[5] = '{16'h7FFE, 1'b0, 16'h7FFE};

    bus.start       = 1'b0;
    bus.feat        = '0;
    bus.data_points = '0;
    bus.S           = 1'b0;
    bus.S_EN        = 1'b0;
    repeat (3) tick();
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_row_valid", bus.row_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done_, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_row_data", 64'(|bus.row_data), 0);
    RST = 1'b1;
    tick();

    // single-word loads: latency, data, row packing, done
    for (int k = 0; k < 6; k++) begin
      do_start(4'd0, 12'd0);
      chk("v_busy", bus.busy, 1);
      chk("v_done_clr", bus.done_, 0);
      send_word(vecs[k].word, vecs[k].gap);
      bus.S_EN = 1'b0;
      chk("v_wr_en_early", bus.wr_en, 0);
      tick();
      chk("v_wr_en", bus.wr_en, 1);
      chk("v_wr_data", bus.wr_data, vecs[k].exp_data);
      chk("v_wr_row", bus.wr_row, 0);
      chk("v_wr_col", bus.wr_col, 0);
      chk("v_row_valid", bus.row_valid, 1);
      chk("v_row_lo", bus.row_data[15:0], vecs[k].exp_data);
      chk("v_row_hi", 64'(|bus.row_data[255:16]), 0);
      chk("v_done_early", bus.done_, 0);
      tick();
      chk("v_wr_en_pulse", bus.wr_en, 0);
      chk("v_rv_pulse", bus.row_valid, 0);
      chk("v_done", bus.done_, 1);
      chk("v_busy_end", bus.busy, 0);
      chk("v_row_hold", bus.row_data[15:0], vecs[k].exp_data);
    end

    // full dataset: feat=11, data_points=4
    base  = wr_q.size();
    rbase = row_q.size();
    do_start(4'd11, 12'd4);
    for (int r = 0; r < 5; r++) begin
      for (int c = 11; c >= 0; c--) begin
        w = 16'(r*256 + c);
        send_word(w, 1'b0);
      end
    end
    bus.S_EN = 1'b0;
    chk("ds_done_early", bus.done_, 0);
    tick();
    chk("ds_last_wr", bus.wr_en, 1);
    chk("ds_last_rv", bus.row_valid, 1);
    chk("ds_done_early2", bus.done_, 0);
    tick();
    chk("ds_done", bus.done_, 1);
    chk("ds_busy", bus.busy, 0);
    chk("ds_err", bus.err, 0);
    chk("ds_wr_count", wr_q.size() - base, 60);
    chk("ds_row_count", row_q.size() - rbase, 5);
    if (wr_q.size() - base == 60) begin
      for (int k = 0; k < 60; k++) begin
        e = {12'(k/12), 4'(11 - k%12), 16'((k/12)*256 + 11 - k%12)};
        chk("ds_word", wr_q[base+k], e);
      end
    end
    if (row_q.size() - rbase == 5) begin
      rd = row_q[rbase+4];
      chk("ds_r4_c11", rd[191:176], 16'h040B);
      chk("ds_r4_hi", 64'(|rd[255:192]), 0);
      chk("ds_r4_c0", rd[15:0], 16'h0400);
      rd = row_q[rbase];
      chk("ds_r0_c10", rd[175:160], 16'h000A);
      chk("ds_r0_c5", rd[95:80], 16'h0005);
    end

    // DONE ignores the bitstream
    base = wr_q.size();
    for (int i = 0; i < 40; i++) send_bit(1'(i % 3));
    bus.S_EN = 1'b0;
    tick();
    chk("done_ignore_wr", wr_q.size() - base, 0);
    chk("done_hold", bus.done_, 1);

    // reset after 7 bits of the second word
    do_start(4'd1, 12'd0);
    send_word(16'h1234, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    bus.S_EN = 1'b0;
    #2 RST = 1'b0;
    #1;
    chk("mr_busy", bus.busy, 0);
    chk("mr_done", bus.done_, 0);
    chk("mr_wr_en", bus.wr_en, 0);
    chk("mr_row_valid", bus.row_valid, 0);
    chk("mr_row_data", 64'(|bus.row_data), 0);
    chk("mr_wr_data", bus.wr_data, 0);
    tick();
    RST  = 1'b1;
    base = wr_q.size();
    for (int i = 0; i < 40; i++) send_bit(1'b1);
    bus.S_EN = 1'b0;
    tick();
    chk("mr_no_wr", wr_q.size() - base, 0);
    chk("mr_idle", bus.busy, 0);
    do_start(4'd1, 12'd0);
    send_word(16'hBEEF, 1'b0);
    send_word(16'h1357, 1'b0);
    bus.S_EN = 1'b0;
    tick();
    tick();
    chk("mr_new_count", wr_q.size() - base, 2);
    if (wr_q.size() - base == 2) begin
      chk("mr_new_w0", wr_q[base], {12'd0, 4'd1, 16'hBEEF});
      chk("mr_new_w1", wr_q[base+1], {12'd0, 4'd0, 16'h1357});
    end
    chk("mr_new_row", bus.row_data[31:0], 32'hBEEF1357);
    chk("mr_new_done", bus.done_, 1);

    // start during LOAD is ignored
    base = wr_q.size();
    do_start(4'd1, 12'd0);
    send_word(16'hAAAA, 1'b0);
    bus.S_EN = 1'b0;
    do_start(4'd5, 12'd3);
    chk("si_busy", bus.busy, 1);
    send_word(16'h5555, 1'b0);
    bus.S_EN = 1'b0;
    tick();
    tick();
    chk("si_count", wr_q.size() - base, 2);
    if (wr_q.size() - base == 2) begin
      chk("si_w0", wr_q[base], {12'd0, 4'd1, 16'hAAAA});
      chk("si_w1", wr_q[base+1], {12'd0, 4'd0, 16'h5555});
    end
    chk("si_done", bus.done_, 1);

`ifdef SERIAL_PARITY_EN
    // wrong parity: word still written, err sticky until start
    do_start(4'd0, 12'd0);
    for (int i = 0; i < WORD_W; i++) send_bit(i == 0);
    send_bit(1'b0);
    bus.S_EN = 1'b0;
    chk("par_err", bus.err, 1);
    tick();
    chk("par_wr_en", bus.wr_en, 1);
    chk("par_wr_data", bus.wr_data, 16'h0001);
    tick();
    chk("par_done", bus.done_, 1);
    chk("par_sticky", bus.err, 1);
    do_start(4'd0, 12'd0);
    chk("par_clr", bus.err, 0);
    send_word(16'h0003, 1'b0);
    bus.S_EN = 1'b0;
    tick();
    tick();
    chk("par_ok_err", bus.err, 0);
    chk("par_ok_done", bus.done_, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
